// File: rtl/bch_gf_pkg.sv
// GF(2^4) arithmetic (primitive polynomial x^4+x+1) and shared types for the
// BCH(15,7) t=2 decode controller.
package bch_gf_pkg;

    localparam int unsigned BCH_N = 15;

    typedef enum logic [2:0] {
        IDLE,
        SYND,
        SOLVE,
        CHIEN,
        DONE
    } state_t;

    // alpha^e for e in 0..14 (alpha^15 wraps to 1)
    function automatic logic [3:0] gf_alog(input logic [3:0] e);
        logic [3:0] r;
        case (e)
            4'd0:    r = 4'd1;
            4'd1:    r = 4'd2;
            4'd2:    r = 4'd4;
            4'd3:    r = 4'd8;
            4'd4:    r = 4'd3;
            4'd5:    r = 4'd6;
            4'd6:    r = 4'd12;
            4'd7:    r = 4'd11;
            4'd8:    r = 4'd5;
            4'd9:    r = 4'd10;
            4'd10:   r = 4'd7;
            4'd11:   r = 4'd14;
            4'd12:   r = 4'd15;
            4'd13:   r = 4'd13;
            4'd14:   r = 4'd9;
            default: r = 4'd1;
        endcase
        return r;
    endfunction

    // discrete log of a nonzero element; log(0) is undefined and returns 0
    function automatic logic [3:0] gf_log(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd1:    r = 4'd0;
            4'd2:    r = 4'd1;
            4'd3:    r = 4'd4;
            4'd4:    r = 4'd2;
            4'd5:    r = 4'd8;
            4'd6:    r = 4'd5;
            4'd7:    r = 4'd10;
            4'd8:    r = 4'd3;
            4'd9:    r = 4'd14;
            4'd10:   r = 4'd9;
            4'd11:   r = 4'd7;
            4'd12:   r = 4'd6;
            4'd13:   r = 4'd13;
            4'd14:   r = 4'd11;
            4'd15:   r = 4'd12;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // exponent reduction mod 15 for sums of at most three logs (< 45)
    function automatic logic [3:0] gf_mod15(input logic [5:0] e);
        logic [5:0] r;
        if (e >= 6'd30) begin
            r = e - 6'd30;
        end else if (e >= 6'd15) begin
            r = e - 6'd15;
        end else begin
            r = e;
        end
        return r[3:0];
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) begin
            return 4'd0;
        end
        return gf_alog(gf_mod15({2'b00, gf_log(a)} + {2'b00, gf_log(b)}));
    endfunction

    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] l;
        if (a == 4'd0) begin
            return 4'd0;
        end
        l = gf_log(a);
        return gf_alog((l == 4'd0) ? 4'd0 : 4'd15 - l);
    endfunction

    function automatic logic [3:0] gf_pow3(input logic [3:0] a);
        logic [3:0] l;
        if (a == 4'd0) begin
            return 4'd0;
        end
        l = gf_log(a);
        return gf_alog(gf_mod15({2'b00, l} + {1'b0, l, 1'b0}));
    endfunction

endpackage

// File: rtl/bch15_chien_step.sv
// One Chien-search step: evaluates 1 + sigma1*x + sigma2*x^2 at x = alpha^(-idx).
module bch15_chien_step
    import bch_gf_pkg::*;
(
    input  logic [3:0] sigma1,
    input  logic [3:0] sigma2,
    input  logic [3:0] idx,
    output logic       is_root
);

    logic [3:0] neg_e;
    logic [3:0] x1;
    logic [3:0] x2;
    logic [3:0] eval;

    // evaluate the locator polynomial at the inverse of position idx
    always_comb begin
        neg_e   = (idx == 4'd0) ? 4'd0 : 4'd15 - idx;
        x1      = gf_alog(neg_e);
        x2      = gf_alog(gf_mod15({1'b0, neg_e, 1'b0}));
        eval    = 4'd1 ^ gf_mul(sigma1, x1) ^ gf_mul(sigma2, x2);
        is_root = (eval == 4'd0);
    end

endmodule

// File: rtl/bch15_decode_ctrl.sv
// Sequencing controller for the BCH(15,7) t=2 decoder: syndrome capture,
// error-locator solve, serial Chien search and result hand-off.
module bch15_decode_ctrl
    import bch_gf_pkg::*;
#(
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_codeword,
    output logic [14:0] syn_codeword,
    input  logic [3:0]  syn_S1,
    input  logic [3:0]  syn_S3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_data,
    output logic [1:0]  out_err_cnt,
    output logic        out_uncorr
);

    state_t      state_q, state_d;
    logic [14:0] rx_q, rx_d;
    logic [14:0] syn_cw_q, syn_cw_d;
    logic [3:0]  s1_q, s1_d;
    logic [3:0]  s3_q, s3_d;
    logic [3:0]  sigma1_q, sigma1_d;
    logic [3:0]  sigma2_q, sigma2_d;
    logic [1:0]  deg_q, deg_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  root_cnt_q, root_cnt_d;
    logic [14:0] work_q, work_d;
    logic        uncorr_q, uncorr_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [14:0] out_data_q, out_data_d;
    logic [1:0]  out_err_cnt_q, out_err_cnt_d;
    logic        out_uncorr_q, out_uncorr_d;

    logic        is_root;
    logic [3:0]  s1_cube;
    logic [14:0] work_nx;
    logic [1:0]  root_nx;
    logic        fail_nx;

    bch15_chien_step u_chien (
        .sigma1  (sigma1_q),
        .sigma2  (sigma2_q),
        .idx     (idx_q),
        .is_root (is_root)
    );

    // next-state and registered-output logic for the decode sequence
    always_comb begin
        state_d       = state_q;
        rx_d          = rx_q;
        syn_cw_d      = syn_cw_q;
        s1_d          = s1_q;
        s3_d          = s3_q;
        sigma1_d      = sigma1_q;
        sigma2_d      = sigma2_q;
        deg_d         = deg_q;
        idx_d         = idx_q;
        root_cnt_d    = root_cnt_q;
        work_d        = work_q;
        uncorr_d      = uncorr_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_err_cnt_d = out_err_cnt_q;
        out_uncorr_d  = out_uncorr_q;

        s1_cube = gf_pow3(s1_q);
        work_nx = work_q ^ (is_root ? (15'd1 << idx_q) : 15'd0);
        root_nx = (is_root && root_cnt_q != 2'd3) ? root_cnt_q + 2'd1 : root_cnt_q;
        fail_nx = uncorr_q || (root_nx != deg_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rx_d       = in_codeword;
                    syn_cw_d   = in_codeword;
                    in_ready_d = 1'b0;
                    state_d    = SYND;
                end
            end

            SYND: begin
                syn_cw_d = rx_q;
                s1_d     = syn_S1;
                s3_d     = syn_S3;
                state_d  = SOLVE;
            end

            SOLVE: begin
                idx_d      = '0;
                root_cnt_d = '0;
                work_d     = rx_q;
                uncorr_d   = 1'b0;
                sigma1_d   = s1_q;
                sigma2_d   = '0;
                if (s1_q == 4'd0 && s3_q == 4'd0) begin
                    deg_d = 2'd0;
                    if (EARLY_EXIT != 0) begin
                        out_data_d    = rx_q;
                        out_err_cnt_d = '0;
                        out_uncorr_d  = 1'b0;
                        out_valid_d   = 1'b1;
                        state_d       = DONE;
                    end else begin
                        state_d = CHIEN;
                    end
                end else if (s1_q == 4'd0) begin
                    // more than two errors: no locator, pass the word through
                    deg_d         = 2'd0;
                    uncorr_d      = 1'b1;
                    out_data_d    = rx_q;
                    out_err_cnt_d = '0;
                    out_uncorr_d  = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else if (s3_q == s1_cube) begin
                    deg_d   = 2'd1;
                    state_d = CHIEN;
                end else begin
                    deg_d    = 2'd2;
                    sigma2_d = gf_mul(s3_q ^ s1_cube, gf_inv(s1_q));
                    state_d  = CHIEN;
                end
            end

            CHIEN: begin
                work_d     = work_nx;
                root_cnt_d = root_nx;
                idx_d      = idx_q + 4'd1;
                if (idx_q == 4'(BCH_N - 1)) begin
                    // final step result is folded in directly so DONE sees position 14
                    uncorr_d      = fail_nx;
                    out_data_d    = fail_nx ? rx_q : work_nx;
                    out_err_cnt_d = fail_nx ? 2'd0 : root_nx;
                    out_uncorr_d  = fail_nx;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // state and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rx_q          <= '0;
            syn_cw_q      <= '0;
            s1_q          <= '0;
            s3_q          <= '0;
            sigma1_q      <= '0;
            sigma2_q      <= '0;
            deg_q         <= '0;
            idx_q         <= '0;
            root_cnt_q    <= '0;
            work_q        <= '0;
            uncorr_q      <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_cnt_q <= '0;
            out_uncorr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_q          <= rx_d;
            syn_cw_q      <= syn_cw_d;
            s1_q          <= s1_d;
            s3_q          <= s3_d;
            sigma1_q      <= sigma1_d;
            sigma2_q      <= sigma2_d;
            deg_q         <= deg_d;
            idx_q         <= idx_d;
            root_cnt_q    <= root_cnt_d;
            work_q        <= work_d;
            uncorr_q      <= uncorr_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_cnt_q <= out_err_cnt_d;
            out_uncorr_q  <= out_uncorr_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign syn_codeword = syn_cw_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err_cnt  = out_err_cnt_q;
    assign out_uncorr   = out_uncorr_q;

endmodule

// File: doc/bch15_decode_ctrl.md
Name: bch15_decode_ctrl

Overview:
Sequencing controller for the BCH(15,7), t=2 decoder over GF(2^4), with primitive polynomial x^4+x+1.
- Accepts received 15-bit words over a valid/ready handshake and drives the external combinational syndrome unit.
- Registers the syndromes, solves the error-locator polynomial, then runs a 15-cycle serial Chien search.
- Emits the corrected word with error count and uncorrectable flag. Processes one word at a time; it sits between the channel deframer and the message extractor.

Parameters:
EARLY_EXIT, 1, when 1 an all-zero syndrome skips the Chien search; when 0 the Chien search always runs.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  received word valid
in_ready  out  1  controller can accept a word
in_codeword  in  15  received word, bit i = coefficient of x^i
syn_codeword  out  15  word presented to syndrome unit
syn_S1  in  4  syndrome S1 from syndrome unit (combinational on syn_codeword)
syn_S3  in  4  syndrome S3 from syndrome unit
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  15  corrected word, or received word if uncorrectable
out_err_cnt  out  2  number of bits corrected (0..2)
out_uncorr  out  1  decode failure

Behaviour:
Clock and reset:
- Single clock domain on clk.
- rst is asynchronous and active-high. It resets every register regardless of state.

Reset values:
- State = IDLE, in_ready=1, out_valid=0.
- out_data=0, out_err_cnt=0, out_uncorr=0.
- syn_codeword=0, Chien index=0.

Handshake:
- in_ready=1 only in IDLE.
- Transfer occurs on a rising edge with in_valid&&in_ready.
- out_valid stays high, with outputs stable, until an edge with out_ready=1.
- in_valid during a busy state is ignored (no capture).

FSM states: IDLE, SYND, SOLVE, CHIEN, DONE.
- IDLE: on transfer edge E0, capture in_codeword into rx_reg and syn_codeword; go to SYND.
- SYND: syn_codeword=rx_reg. On E1, register s1=syn_S1, s3=syn_S3; go to SOLVE.
- SOLVE (on E2):
  - s1=0 and s3=0: sigma1=0, sigma2=0, deg=0. Go to DONE if EARLY_EXIT=1, else to CHIEN.
  - s1=0 and s3!=0: uncorr=1; go to DONE.
  - s3 = s1^3: deg=1, sigma1=s1, sigma2=0; go to CHIEN.
  - otherwise: deg=2, sigma1=s1, sigma2=(s3 + s1^3)*inv(s1); go to CHIEN.
  - On entry to CHIEN: idx=0, root_cnt=0, work=rx_reg.
- CHIEN (edges E3..E17, idx 0..14):
  - Evaluate 1 + sigma1*a^(-idx) + sigma2*a^(-2idx), with exponents mod 15.
  - If the result is zero: flip work[idx] and increment root_cnt (saturating at 3).
  - At idx=14, go to DONE.
- DONE entry:
  - out_data = work if !uncorr, else rx_reg.
  - out_err_cnt = root_cnt if !uncorr, else 0.
  - uncorr is also set when root_cnt != deg.
  - out_valid=1.
- DONE on out_ready: out_valid=0, go to IDLE. in_ready rises the following cycle; there is no same-cycle turnaround.

Latency:
- out_valid is high after E17 (17 cycles after acceptance) when CHIEN runs.
- out_valid is high after E2 for the early-exit and s1=0 uncorrectable paths.

Arithmetic:
- All GF ops are log/antilog based. Multiplication by zero yields 0.
- inv(s1) is used only when s1!=0.

Decomposition:
- Package bch_gf_pkg holds:
  - GF(2^4) antilog/log constants, gf_mul, gf_inv, gf_pow3.
  - BCH_N=15.
  - State enum encoding.
- One natural sub-module: bch15_chien_step, a combinational evaluator of sigma at a^(-idx) that returns is_root.
- The syndrome unit stays external and is connected via the syn_* ports.

Test Plan:
- Clean word 0 accepted, EARLY_EXIT=1 -> out_valid 2 cycles after accept; out_data=0, out_err_cnt=0, out_uncorr=0.
- Single error, bit 3 set in all-zero word (S1=4'b1000, S3=4'b1010) -> after 17 cycles out_data=0, out_err_cnt=1, out_uncorr=0.
- Double error, bits 0 and 5 (S1=4'b0111, S3=0) -> out_data=0, out_err_cnt=2, out_uncorr=0.
- Triple error, bits {0,1,4} (S1=0, S3=4'b0110) -> out_valid after 2 cycles; out_uncorr=1, out_data=15'h0013, out_err_cnt=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses ignored; release -> in_ready=1 next cycle.
- Assert rst mid-CHIEN (idx=7) -> immediately IDLE, in_ready=1, out_valid=0; the next word decodes correctly.
